// File: rtl/fsm_result_sink.sv
// Result sink for the mini processing FSM: classifies each transaction as RESULT/ERROR/TIMEOUT
// and queues the outcome in a small tagged first-word-fall-through FIFO with a valid/ready port.
module fsm_result_sink #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned ERR_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [7:0]  fsm_data_out,
  input  logic        fsm_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic [1:0]  m_tag,
  output logic        busy,
  output logic [15:0] txn_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;
  localparam int unsigned ERR_W = $clog2(ERR_HOLD) + 1;

  localparam logic [7:0] ERR_CODE    = 8'hEE;
  localparam logic [1:0] TAG_RESULT  = 2'b00;
  localparam logic [1:0] TAG_ERROR   = 2'b01;
  localparam logic [1:0] TAG_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [1:0] tag;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    ERRWAIT = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [ERR_W-1:0]   errcnt, errcnt_next;
  logic               push_c;
  entry_t             push_word;

  logic               is_err_c, err_hit_c, tmo_hit_c;

  assign is_err_c  = (fsm_data_out == ERR_CODE);
  assign err_hit_c = is_err_c && (errcnt == ERR_W'(ERR_HOLD - 1));
  assign tmo_hit_c = (timer == TMR_W'(TIMEOUT - 1));

  // State register; busy is registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      timer  <= '0;
      errcnt <= '0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE);
      timer  <= timer_next;
      errcnt <= errcnt_next;
    end
  end

  // Next state: done wins over error, error wins over timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = ACTIVE;
      ACTIVE: begin
        if (fsm_done)       state_next = IDLE;
        else if (err_hit_c) state_next = ERRWAIT;
        else if (tmo_hit_c) state_next = IDLE;
      end
      ERRWAIT: if (!is_err_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: FIFO push request and timer/error-run bookkeeping.
  always_comb begin
    push_c      = 1'b0;
    push_word   = '0;
    timer_next  = timer;
    errcnt_next = errcnt;
    case (state)
      IDLE: begin
        if (start_in) begin
          timer_next  = '0;
          errcnt_next = '0;
        end
      end
      ACTIVE: begin
        timer_next  = TMR_W'(timer + 1'b1);
        errcnt_next = is_err_c ? ERR_W'(errcnt + 1'b1) : '0;
        if (fsm_done) begin
          push_c    = 1'b1;
          push_word = '{tag: TAG_RESULT, data: fsm_data_out};
        end else if (err_hit_c) begin
          push_c    = 1'b1;
          push_word = '{tag: TAG_ERROR, data: ERR_CODE};
        end else if (tmo_hit_c) begin
          push_c    = 1'b1;
          push_word = '{tag: TAG_TIMEOUT, data: 8'h00};
        end
      end
      default: ;
    endcase
  end

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               pop_c, full_c, push_ok_c;
  entry_t             head_next;

  assign pop_c       = m_valid & m_ready;
  assign full_c      = (count == CNT_W'(DEPTH));
  assign push_ok_c   = push_c & (~full_c | pop_c);
  assign rd_ptr_next = pop_c ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;

  always_comb begin
    count_next = count;
    if (push_ok_c && !pop_c)      count_next = CNT_W'(count + 1'b1);
    else if (!push_ok_c && pop_c) count_next = CNT_W'(count - 1'b1);
  end

  // New head comes from the incoming push when it lands straight at the read pointer.
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (count_next == '0)                           head_next = '0;
    else if (push_ok_c && (rd_ptr_next == wr_ptr))  head_next = push_word;
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      m_valid  <= 1'b0;
      m_tag    <= '0;
      m_data   <= '0;
      txn_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      m_valid <= (count_next != '0);
      m_tag   <= head_next.tag;
      m_data  <= head_next.data;
      if (push_ok_c && (push_word.tag == TAG_RESULT)) txn_cnt <= 16'(txn_cnt + 1'b1);
      if (push_c && !push_ok_c && (drop_cnt != 8'hFF)) drop_cnt <= 8'(drop_cnt + 1'b1);
    end
  end

endmodule

// File: tb/tb_fsm_result_sink.sv
// Directed bench for fsm_result_sink with a scoreboard of expected FIFO entries.
module tb_fsm_result_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [7:0]  fsm_data_out;
  logic        fsm_done;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_tag;
  logic        busy;
  logic [15:0] txn_cnt;
  logic [7:0]  drop_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [9:0]  exp_q[$];

  fsm_result_sink dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .fsm_data_out (fsm_data_out),
    .fsm_done     (fsm_done),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_tag        (m_tag),
    .busy         (busy),
    .txn_cnt      (txn_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // A result transaction: start, then done with data on the first ACTIVE cycle.
  task automatic quick_txn(input logic [7:0] d, input bit expect_kept);
    start_in = 1'b1;
    tick();
    start_in     = 1'b0;
    fsm_done     = 1'b1;
    fsm_data_out = d;
    if (expect_kept) exp_q.push_back({2'b00, d});
    tick();
    fsm_done     = 1'b0;
    fsm_data_out = 8'h00;
  endtask

  // Scoreboard: compare the head whenever the next edge will pop it.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed %0h expected none", {m_tag, m_data});
      end
      if (exp_q.size() != 0) chk("sb_entry", 16'({m_tag, m_data}), 16'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_in = 1'b0; fsm_data_out = 8'h00; fsm_done = 1'b0; m_ready = 1'b1;
    ticks(2);
    chk("rst_valid", 16'(m_valid), 16'd0);
    chk("rst_data",  16'(m_data),  16'd0);
    chk("rst_tag",   16'(m_tag),   16'd0);
    chk("rst_busy",  16'(busy),    16'd0);
    chk("rst_txn",   txn_cnt,      16'd0);
    chk("rst_drop",  16'(drop_cnt), 16'd0);
    rst = 1'b0;
    tick();

    // RESULT after six cycles
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("t1_busy_on", 16'(busy), 16'd1);
    ticks(5);
    chk("t1_no_entry", 16'(m_valid), 16'd0);
    fsm_done = 1'b1; fsm_data_out = 8'h5A;
    exp_q.push_back({2'b00, 8'h5A});
    tick();
    fsm_done = 1'b0; fsm_data_out = 8'h00;
    chk("t1_valid", 16'(m_valid), 16'd1);
    chk("t1_tag",   16'(m_tag),   16'd0);
    chk("t1_data",  16'(m_data),  16'h5A);
    chk("t1_txn",   txn_cnt,      16'd1);
    chk("t1_busy",  16'(busy),    16'd0);
    tick();
    chk("t1_drained", 16'(m_valid), 16'd0);

    // ERROR after four 0xEE cycles, start ignored while busy
    start_in = 1'b1;
    tick();
    start_in = 1'b0; fsm_data_out = 8'hEE;
    ticks(3);
    chk("t2_no_entry", 16'(m_valid), 16'd0);
    start_in = 1'b1;
    exp_q.push_back({2'b01, 8'hEE});
    tick();
    chk("t2_valid", 16'(m_valid), 16'd1);
    chk("t2_tag",   16'(m_tag),   16'd1);
    chk("t2_data",  16'(m_data),  16'hEE);
    chk("t2_busy",  16'(busy),    16'd1);
    tick();
    chk("t2_busy_hold", 16'(busy), 16'd1);
    fsm_data_out = 8'h00; start_in = 1'b0;
    tick();
    chk("t2_busy_off", 16'(busy),    16'd0);
    chk("t2_txn",      txn_cnt,      16'd1);
    chk("t2_one_only", 16'(m_valid), 16'd0);

    // Interrupted 0xEE run, then RESULT
    start_in = 1'b1;
    tick();
    start_in = 1'b0; fsm_data_out = 8'hEE;
    ticks(3);
    fsm_data_out = 8'h10;
    tick();
    chk("t3_no_err", 16'(m_valid), 16'd0);
    fsm_done = 1'b1; fsm_data_out = 8'h33;
    exp_q.push_back({2'b00, 8'h33});
    tick();
    fsm_done = 1'b0; fsm_data_out = 8'h00;
    chk("t3_tag",  16'(m_tag),  16'd0);
    chk("t3_data", 16'(m_data), 16'h33);
    chk("t3_txn",  txn_cnt,     16'd2);
    tick();

    // TIMEOUT on the 64th ACTIVE cycle
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    ticks(63);
    chk("t4_not_yet", 16'(m_valid), 16'd0);
    chk("t4_busy",    16'(busy),    16'd1);
    exp_q.push_back({2'b10, 8'h00});
    tick();
    chk("t4_valid", 16'(m_valid), 16'd1);
    chk("t4_tag",   16'(m_tag),   16'd2);
    chk("t4_data",  16'(m_data),  16'h00);
    chk("t4_busy_off", 16'(busy), 16'd0);
    chk("t4_txn",   txn_cnt,      16'd2);
    tick();

    // Overflow: five results into a four-entry FIFO
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_txn_clr", txn_cnt, 16'd0);
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) quick_txn(8'(k), k <= 4);
    chk("t5_drop",  16'(drop_cnt), 16'd1);
    chk("t5_txn",   txn_cnt,       16'd4);
    chk("t5_head",  16'(m_data),   16'h01);
    tick();
    chk("t5_hold",  16'(m_data),   16'h01);
    m_ready = 1'b1;
    ticks(4);
    chk("t5_empty", 16'(m_valid),  16'd0);

    // Full FIFO with simultaneous pop accepts the push
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) quick_txn(8'(8'h11 + k), 1'b1);
    chk("t6_drop_pre", 16'(drop_cnt), 16'd1);
    start_in = 1'b1;
    tick();
    start_in = 1'b0; fsm_done = 1'b1; fsm_data_out = 8'h15; m_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h15});
    tick();
    fsm_done = 1'b0; fsm_data_out = 8'h00; m_ready = 1'b0;
    chk("t6_head",  16'(m_data),   16'h12);
    chk("t6_drop",  16'(drop_cnt), 16'd1);
    chk("t6_txn",   txn_cnt,       16'd9);
    quick_txn(8'h16, 1'b0);
    chk("t6_still_full", 16'(drop_cnt), 16'd2);
    m_ready = 1'b1;
    ticks(2);
    m_ready = 1'b0;
    chk("t6_head2", 16'(m_data), 16'h14);

    // Reset in the middle of a transaction with two queued entries
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    chk("t6_busy_pre", 16'(busy), 16'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 16'(m_valid),  16'd0);
    chk("t6_rst_busy",  16'(busy),     16'd0);
    chk("t6_rst_txn",   txn_cnt,       16'd0);
    chk("t6_rst_drop",  16'(drop_cnt), 16'd0);
    tick();
    chk("t6_rst_stay",  16'(m_valid),  16'd0);

    // Normal operation resumes after reset
    m_ready = 1'b1;
    quick_txn(8'h77, 1'b1);
    chk("post_data", 16'(m_data), 16'h77);
    chk("post_txn",  txn_cnt,     16'd1);
    ticks(2);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
